fp_mant_div_seq: RTL and testbench
==================================

# fp_mant_div_seq

Sequential restoring mantissa divider for the IEEE-754 single-precision division path. It takes two 24-bit significands with the hidden bit included and produces a 26-bit quotient plus a sticky bit for the normalise/round stage. It produces one quotient bit per cycle. Each trial subtraction is performed by adding the two's complement of the divisor, which is computed once when the operands are accepted.

## Interface
Parameters:
- MANT_W, default 24: significand width, hidden bit included.
- QUOT_W, default MANT_W+2: quotient width, made up of 1 integer bit, MANT_W fraction bits and 1 guard bit.

Ports:
- clk  in  1  Single clock; all state changes on the rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- in_valid  in  1  Operands a_mant and b_mant are valid.
- in_ready  out  1  Block is able to accept operands. High only in IDLE.
- a_mant  in  MANT_W  Dividend significand.
- b_mant  in  MANT_W  Divisor significand.
- out_valid  out  1  Result outputs are valid. High only in DONE.
- out_ready  in  1  Downstream consumes the result.
- quot  out  QUOT_W  Quotient, equal to floor(a·2^(QUOT_W-1)/b).
- sticky  out  1  Final remainder is non-zero.
- dbz  out  1  Divide-by-zero: b_mant was 0.

## Operation
- State machine states: IDLE, CALC, DONE.
  - IDLE → CALC on in_valid && in_ready, when b_mant ≠ 0.
  - IDLE → DONE on accept, when b_mant = 0.
  - CALC → DONE after the step with cnt = 0.
  - DONE → IDLE on out_valid && out_ready.
- On accept:
  - R ← {1'b0, a_mant}. R is MANT_W+1 bits wide.
  - nb ← two's complement of {1'b0, b_mant}, at MANT_W+1 bits.
  - cnt ← QUOT_W-1.
  - q ← 0.
- Each CALC cycle:
  - T = R + nb at MANT_W+2 bits. The carry-out equals 1 exactly when R ≥ b.
  - When the carry is 1: q[cnt] ← 1 and R_next ← T[MANT_W:0]. Otherwise q[cnt] ← 0 and R_next ← R.
  - When cnt ≠ 0: R ← R_next << 1 and cnt decrements.
  - When cnt = 0: R ← R_next with no shift, and the state moves to DONE.
- Width invariant: R < 2b holds at every compare. This follows because both operands lie in [1,2) or a < 2b. As a result the shifted remainder always fits in MANT_W+1 bits. The block does not check this invariant; operands that break it give an undefined quotient.
- sticky = (R ≠ 0), evaluated in DONE.
- dbz path:
  - quot is all ones.
  - sticky = 0.
  - dbz = 1.
  - No CALC cycles are run.
- Outputs quot, sticky and dbz are registered. They are held stable for as long as out_valid is high and out_ready is low.

## Timing
- Reset state:
  - State is IDLE.
  - in_ready = 1.
  - out_valid = 0.
  - quot = 0, sticky = 0, dbz = 0.
  - cnt = 0, R = 0.
- Latency:
  - Normal operands: out_valid goes high QUOT_W+1 = 27 rising edges after the accepting edge, which is 26 CALC cycles plus the entry edge.
  - dbz: out_valid goes high 1 edge after the accepting edge.
- Throughput: one operation per QUOT_W+2 cycles at best. This includes one IDLE bubble after each result is consumed.
- in_ready is low throughout CALC and DONE. Upstream must hold its operands until the handshake completes.
- Simultaneous events: inputs arriving while the block is in DONE are ignored until it returns to IDLE. The out_ready handshake is the only way to leave DONE.
- When rst_n is asserted mid-operation, the block returns to reset state immediately, without waiting for a clock edge. The partial result is discarded and no out_valid is produced.

## Structure
- Package fp_div_pkg holds:
  - MANT_W, QUOT_W.
  - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t.
  - typedef logic [MANT_W-1:0] mant_t.
- Sub-module div_sub_step is combinational. It takes R and nb and outputs R_next and q_bit using carry-add subtraction, and is instantiated once.
- The counter, FSM and registers stay in fp_mant_div_seq.

## Test plan
- a = 0x800000, b = 0x800000 → after 27 edges: quot = 0x2000000, sticky = 0, dbz = 0.
- a = 0xC00000, b = 0x800000 → quot = 0x3000000, sticky = 0.
- a = 0x800000, b = 0xC00000 → quot = 0x1555555, sticky = 1.
- a = 0xFFFFFF, b = 0x800000 → quot = 0x3FFFFFC, sticky = 0. Then hold out_ready low for 5 cycles and check:
  - outputs stay stable;
  - in_ready stays 0;
  - a new in_valid is ignored.
- b = 0, any a → out_valid 1 edge after accept, with dbz = 1, quot = 0x3FFFFFF and sticky = 0.
- Assert rst_n low at CALC step 10 → out_valid and quot are 0 and in_ready is 1 immediately. A subsequent operation using the first scenario's values gives the correct result.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared types for the sequential significand divider.
// Holds widths, FSM state encoding and the significand type.
package fp_div_pkg;

    localparam int MANT_W = 24;
    localparam int QUOT_W = MANT_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    typedef logic [MANT_W-1:0] mant_t;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract via carry-add.
// r, nb in (W+1 bits); r_next out, q_bit = carry (r >= b).
module div_sub_step #(
    parameter int W = 24
) (
    input  logic [W:0] r,
    input  logic [W:0] nb,
    output logic [W:0] r_next,
    output logic       q_bit
);

    logic [W+1:0] t;

    always_comb begin
        t      = {1'b0, r} + {1'b0, nb};
        q_bit  = t[W+1];
        r_next = q_bit ? t[W:0] : r;
    end

endmodule

// File: rtl/fp_mant_div_seq.sv
// Sequential restoring significand divider, one quotient bit per cycle.
// Ports: in_valid/in_ready + a_mant/b_mant in; out_valid/out_ready + quot/sticky/dbz out.
module fp_mant_div_seq #(
    parameter int MANT_W = 24,
    parameter int QUOT_W = MANT_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] a_mant,
    input  logic [MANT_W-1:0] b_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [QUOT_W-1:0] quot,
    output logic              sticky,
    output logic              dbz
);

    import fp_div_pkg::*;

    localparam int RW    = MANT_W + 1;
    localparam int CNT_W = $clog2(QUOT_W);

    div_state_t        state_q;
    div_state_t        state_d;
    logic [CNT_W-1:0]  cnt;
    logic [RW-1:0]     r;
    logic [RW-1:0]     nb;
    logic [RW-1:0]     r_next;
    logic              q_bit;
    logic [QUOT_W-1:0] q;
    logic              sticky_q;
    logic              dbz_q;
    logic              accept;
    logic              b_zero;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign b_zero    = (b_mant == '0);
    assign quot      = q;
    assign sticky    = sticky_q;
    assign dbz       = dbz_q;

    div_sub_step #(
        .W(MANT_W)
    ) u_step (
        .r     (r),
        .nb    (nb),
        .r_next(r_next),
        .q_bit (q_bit)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = b_zero ? DONE : CALC;
            CALC: if (cnt == '0) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r        <= '0;
            nb       <= '0;
            cnt      <= '0;
            q        <= '0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (accept) begin
            r        <= {1'b0, a_mant};
            // Negated divisor computed once; each step is then a plain add.
            nb       <= (~{1'b0, b_mant}) + RW'(1);
            cnt      <= CNT_W'(QUOT_W - 1);
            q        <= b_zero ? '1 : '0;
            sticky_q <= 1'b0;
            dbz_q    <= b_zero;
        end else if (state_q == CALC) begin
            q[cnt] <= q_bit;
            if (cnt == '0) begin
                r        <= r_next;
                sticky_q <= (r_next != '0);
            end else begin
                // r_next < b, so the top bit is zero and the shift cannot overflow.
                r   <= {r_next[MANT_W-1:0], 1'b0};
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_mant_div_seq.sv
// Self-checking bench for fp_mant_div_seq.
// Directed vectors, hold/reset sequences and random ops vs arithmetic model.
module tb_fp_mant_div_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a_mant;
    logic [23:0] b_mant;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] quot;
    logic        sticky;
    logic        dbz;

    int n_tests = 0;
    int n_fail  = 0;

    fp_mant_div_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_mant   (a_mant),
        .b_mant   (b_mant),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot     (quot),
        .sticky   (sticky),
        .dbz      (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [25:0] q;
        logic        s;
        logic        d;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                          output logic [25:0] q, output logic s,
                          output logic d, output int lat,
                          input bit consume);
        int w;
        @(negedge clk);
        a_mant   = a;
        b_mant   = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("accept_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q = quot;
        s = sticky;
        d = dbz;
        if (consume) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [25:0] q;
        logic        s;
        logic        d;
        int          lat;
        logic [63:0] num;
        logic [23:0] ra;
        logic [23:0] rb;

        vecs[0] = '{24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0, 27};
        vecs[1] = '{24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, 27};
        vecs[2] = '{24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0, 27};
        vecs[3] = '{24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b0, 27};
        vecs[4] = '{24'h123456, 24'h000000, 26'h3FFFFFF, 1'b0, 1'b1, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_mant    = '0;
        b_mant    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quot", 64'(quot), 64'd0);
        check("rst_sticky", 64'(sticky), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, q, s, d, lat, 1'b1);
            check($sformatf("vec%0d_quot", i), 64'(q), 64'(vecs[i].q));
            check($sformatf("vec%0d_sticky", i), 64'(s), 64'(vecs[i].s));
            check($sformatf("vec%0d_dbz", i), 64'(d), 64'(vecs[i].d));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Hold result with out_ready low while upstream keeps offering.
        run_op(24'hFFFFFF, 24'h800000, q, s, d, lat, 1'b0);
        check("hold_init_quot", 64'(q), 64'h3FFFFFC);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_mant   = 24'h800000;
            b_mant   = 24'h000000;
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("hold%0d_quot", i), 64'(quot), 64'h3FFFFFC);
            check($sformatf("hold%0d_sticky", i), 64'(sticky), 64'd0);
            check($sformatf("hold%0d_dbz", i), 64'(dbz), 64'd0);
            check($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_release_valid", 64'(out_valid), 64'd0);
        check("hold_release_ready", 64'(in_ready), 64'd1);
        check("hold_release_dbz", 64'(dbz), 64'd0);

        // Asynchronous reset part-way through the calculation.
        @(negedge clk);
        a_mant   = 24'hC00000;
        b_mant   = 24'h800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_quot", 64'(quot), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(24'h800000, 24'h800000, q, s, d, lat, 1'b1);
        check("arst_after_quot", 64'(q), 64'h2000000);
        check("arst_after_sticky", 64'(s), 64'd0);
        check("arst_after_lat", 64'(lat), 64'd27);

        // Random normalised significands against exact arithmetic.
        for (int i = 0; i < 40; i++) begin
            ra  = 24'h800000 | 24'($urandom);
            rb  = 24'h800000 | 24'($urandom);
            num = 64'(ra) << 25;
            run_op(ra, rb, q, s, d, lat, 1'b1);
            check($sformatf("rnd%0d_quot a=%h b=%h", i, ra, rb),
                  64'(q), num / 64'(rb));
            check($sformatf("rnd%0d_sticky", i), 64'(s),
                  64'((num % 64'(rb)) != 0));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'd27);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
